// File: rtl/decode_exec_reg.sv
// decode_exec_reg: ID/EX pipeline register with load-use stall FSM, flush squash and downstream hold.
// Define DECODE_EXEC_STALL_COUNT_EN to add stall_cnt, a wrapping count of hazard-induced stall cycles.
module decode_exec_reg #(
  parameter int CTRL_W   = 8,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_r2,
  input  logic [3:0]        id_r3,
  input  logic [31:0]       id_r2_val,
  input  logic [31:0]       id_r3_val,
  input  logic [3:0]        id_dest,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [3:0]        ex_r2,
  output logic [3:0]        ex_r3,
  output logic [31:0]       ex_r2_val,
  output logic [31:0]       ex_r3_val,
  output logic [3:0]        ex_dest,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef DECODE_EXEC_STALL_COUNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              stall
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       hazard;
  logic       take_id;
  logic       take_bubble;

  // Both sources matching the same load destination is still a single hazard.
  assign hazard = ex_valid & ex_is_load & ex_wr_en & id_valid &
                  ((id_r2 == ex_dest) | (id_r3 == ex_dest));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
    end else if (!ex_hold) begin
      unique case (state)
        RUN: begin
          if (hazard) begin
            cnt_nxt   = CNT_INIT;
            state_nxt = (LOAD_LAT > 1) ? STALL : RUN;
          end
        end
        STALL: begin
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = RUN;
        end
      endcase
    end
  end

  // The hazard cycle in RUN counts as the first of the LOAD_LAT stall cycles.
  always_comb begin
    stall       = 1'b0;
    take_id     = 1'b0;
    take_bubble = 1'b0;
    if (!rst_n) begin
      stall = 1'b0;
    end else if (flush) begin
      take_bubble = 1'b1;
    end else if (ex_hold) begin
      stall = 1'b1;
    end else if (state == STALL || hazard) begin
      stall       = 1'b1;
      take_bubble = 1'b1;
    end else begin
      take_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_r2      <= '0;
      ex_r3      <= '0;
      ex_r2_val  <= '0;
      ex_r3_val  <= '0;
      ex_dest    <= '0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else if (take_bubble) begin
      ex_valid   <= 1'b0;
      ex_r2      <= '0;
      ex_r3      <= '0;
      ex_r2_val  <= '0;
      ex_r3_val  <= '0;
      ex_dest    <= '0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else if (take_id) begin
      ex_valid   <= id_valid;
      ex_r2      <= id_r2;
      ex_r3      <= id_r3;
      ex_r2_val  <= id_r2_val;
      ex_r3_val  <= id_r3_val;
      ex_dest    <= id_dest;
      ex_wr_en   <= id_wr_en;
      ex_is_load <= id_is_load;
      ex_ctrl    <= id_ctrl;
    end
  end

`ifdef DECODE_EXEC_STALL_COUNT_EN
  // Hold-induced stalls are excluded; flush cycles never stall so they never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (stall && !ex_hold) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_exec_reg.sv
// Directed bench for decode_exec_reg: two instances (LOAD_LAT=2 and 3) share one stimulus stream.
module tb_decode_exec_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_r2, id_r3, id_dest;
  logic [31:0] id_r2_val, id_r3_val;
  logic        id_wr_en, id_is_load;
  logic [7:0]  id_ctrl;
  logic        flush, ex_hold;

  logic        d2_valid, d2_wr_en, d2_is_load, d2_stall;
  logic [3:0]  d2_r2, d2_r3, d2_dest;
  logic [31:0] d2_r2_val, d2_r3_val;
  logic [7:0]  d2_ctrl;
  logic        d3_valid, d3_wr_en, d3_is_load, d3_stall;
  logic [3:0]  d3_r2, d3_r3, d3_dest;
  logic [31:0] d3_r2_val, d3_r3_val;
  logic [7:0]  d3_ctrl;
`ifdef DECODE_EXEC_STALL_COUNT_EN
  logic [31:0] d2_cnt, d3_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_exec_reg #(.CTRL_W(8), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r2(id_r2), .id_r3(id_r3),
    .id_r2_val(id_r2_val), .id_r3_val(id_r3_val), .id_dest(id_dest), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
    .ex_valid(d2_valid), .ex_r2(d2_r2), .ex_r3(d2_r3), .ex_r2_val(d2_r2_val),
    .ex_r3_val(d2_r3_val), .ex_dest(d2_dest), .ex_wr_en(d2_wr_en), .ex_is_load(d2_is_load),
    .ex_ctrl(d2_ctrl),
`ifdef DECODE_EXEC_STALL_COUNT_EN
    .stall_cnt(d2_cnt),
`endif
    .stall(d2_stall)
  );

  decode_exec_reg #(.CTRL_W(8), .LOAD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r2(id_r2), .id_r3(id_r3),
    .id_r2_val(id_r2_val), .id_r3_val(id_r3_val), .id_dest(id_dest), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
    .ex_valid(d3_valid), .ex_r2(d3_r2), .ex_r3(d3_r3), .ex_r2_val(d3_r2_val),
    .ex_r3_val(d3_r3_val), .ex_dest(d3_dest), .ex_wr_en(d3_wr_en), .ex_is_load(d3_is_load),
    .ex_ctrl(d3_ctrl),
`ifdef DECODE_EXEC_STALL_COUNT_EN
    .stall_cnt(d3_cnt),
`endif
    .stall(d3_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] r2, input logic [3:0] r3,
                       input logic [31:0] r2v, input logic [31:0] r3v, input logic [3:0] dest,
                       input logic wr, input logic ld, input logic [7:0] ctrl);
    id_valid   = v;
    id_r2      = r2;
    id_r3      = r3;
    id_r2_val  = r2v;
    id_r3_val  = r3v;
    id_dest    = dest;
    id_wr_en   = wr;
    id_is_load = ld;
    id_ctrl    = ctrl;
  endtask

  // Registered outputs are sampled 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_to_dest4();
    drive(1'b1, 4'd1, 4'd2, 32'h0, 32'h0, 4'd4, 1'b1, 1'b1, 8'h33);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    ex_hold = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 8'h0);
    #2;
    check("rst_stall_with_hold", 32'(d2_stall), 0);
    check("rst_valid", 32'(d2_valid), 0);
    check("rst_r2_val", d2_r2_val, 0);
    tick();
    rst_n   = 1'b1;
    ex_hold = 1'b0;
    #1 check("post_rst_stall", 32'(d2_stall), 0);

    // Normal capture
    drive(1'b1, 4'd3, 4'd0, 32'h1234, 32'h0, 4'd5, 1'b1, 1'b0, 8'hA5);
    #1 check("norm_stall", 32'(d2_stall), 0);
    tick();
    check("norm_valid", 32'(d2_valid), 1);
    check("norm_r2", 32'(d2_r2), 3);
    check("norm_r2_val", d2_r2_val, 32'h1234);
    check("norm_dest", 32'(d2_dest), 5);
    check("norm_ctrl", 32'(d2_ctrl), 32'hA5);
    check("norm_r2_val_l3", d3_r2_val, 32'h1234);

    // id_valid=0 still loads fields, with ex_valid=0
    drive(1'b0, 4'd7, 4'd4, 32'hBEEF, 32'h4444, 4'd9, 1'b1, 1'b1, 8'h5A);
    #1 check("inv_stall", 32'(d2_stall), 0);
    tick();
    check("inv_valid", 32'(d2_valid), 0);
    check("inv_r2", 32'(d2_r2), 7);
    check("inv_r2_val", d2_r2_val, 32'hBEEF);
    check("inv_is_load", 32'(d2_is_load), 1);
    check("inv_dest", 32'(d2_dest), 9);
    drive(1'b1, 4'd9, 4'd9, 32'h0, 32'h0, 4'd1, 1'b1, 1'b0, 8'h0);
    #1 check("inv_ex_nohaz", 32'(d2_stall), 0);

    // Load-use hazard: LOAD_LAT=2 stalls 2 cycles, LOAD_LAT=3 stalls 3
    load_to_dest4();
    check("ld_valid", 32'(d2_valid), 1);
    check("ld_dest", 32'(d2_dest), 4);
    drive(1'b0, 4'd6, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    #1 check("idv0_nohaz", 32'(d2_stall), 0);
    id_valid = 1'b1;
    #1 check("lu_stall0", 32'(d2_stall), 1);
    check("lu_stall0_l3", 32'(d3_stall), 1);
    tick();
    check("lu_b1_valid", 32'(d2_valid), 0);
    check("lu_b1_r3", 32'(d2_r3), 0);
    check("lu_stall1", 32'(d2_stall), 1);
    check("lu_stall1_l3", 32'(d3_stall), 1);
    tick();
    check("lu_b2_valid", 32'(d2_valid), 0);
    check("lu_stall2", 32'(d2_stall), 0);
    check("lu_stall2_l3", 32'(d3_stall), 1);
    tick();
    check("lu_out_valid", 32'(d2_valid), 1);
    check("lu_out_r3", 32'(d2_r3), 4);
    check("lu_out_r3_val", d2_r3_val, 32'h44);
    check("lu_out_dest", 32'(d2_dest), 7);
    check("lu_stall3_l3", 32'(d3_stall), 0);
    check("lu_b3_valid_l3", 32'(d3_valid), 0);
    tick();
    check("lu_out_valid_l3", 32'(d3_valid), 1);
    check("lu_out_r3_val_l3", d3_r3_val, 32'h44);

    // Both sources on the load dest, then flush in the 2nd stall cycle
    load_to_dest4();
    drive(1'b1, 4'd4, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    #1 check("dual_haz_stall", 32'(d3_stall), 1);
    tick();
    check("fl_pre_stall_l3", 32'(d3_stall), 1);
    flush = 1'b1;
    #1 check("fl_stall_l3", 32'(d3_stall), 0);
    check("fl_stall", 32'(d2_stall), 0);
    tick();
    check("fl_bubble_l3", 32'(d3_valid), 0);
    flush = 1'b0;
    drive(1'b1, 4'd4, 4'd0, 32'hCAFE, 32'h0, 4'hA, 1'b1, 1'b0, 8'h77);
    #1 check("fl_run_l3", 32'(d3_stall), 0);
    tick();
    check("fl_next_valid_l3", 32'(d3_valid), 1);
    check("fl_next_r2_val_l3", d3_r2_val, 32'hCAFE);
    check("fl_next_dest_l3", 32'(d3_dest), 32'hA);
    check("fl_next_r2_val", d2_r2_val, 32'hCAFE);

    // Hold freezes valid contents for 3 cycles; flush overrides hold
    ex_hold = 1'b1;
    drive(1'b1, 4'd2, 4'd0, 32'h0BAD, 32'h0, 4'd3, 1'b1, 1'b0, 8'h01);
    #1 check("hold_stall0", 32'(d2_stall), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 32'(d2_valid), 1);
      check("hold_r2_val", d2_r2_val, 32'hCAFE);
      check("hold_dest", 32'(d2_dest), 32'hA);
      check("hold_stall", 32'(d2_stall), 1);
    end
    flush = 1'b1;
    #1 check("hold_fl_stall", 32'(d2_stall), 0);
    tick();
    check("hold_fl_bubble", 32'(d2_valid), 0);
    flush   = 1'b0;
    ex_hold = 1'b0;

    // Hold during STALL freezes the FSM and counter
    load_to_dest4();
    drive(1'b1, 4'd6, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    #1 check("hs_stall0", 32'(d2_stall), 1);
    tick();
    ex_hold = 1'b1;
    tick();
    check("hs_held_stall", 32'(d2_stall), 1);
    check("hs_held_valid", 32'(d2_valid), 0);
    ex_hold = 1'b0;
    #1 check("hs_resume_stall", 32'(d2_stall), 1);
    tick();
    check("hs_done_stall", 32'(d2_stall), 0);
    tick();
    check("hs_out_valid", 32'(d2_valid), 1);
    check("hs_out_r3_val", d2_r3_val, 32'h44);

    // Asynchronous reset between edges clears valid contents immediately
    load_to_dest4();
    drive(1'b1, 4'd6, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    #2;
    rst_n = 1'b0;
    #1 check("ar_valid", 32'(d2_valid), 0);
    check("ar_is_load", 32'(d2_is_load), 0);
    check("ar_dest", 32'(d2_dest), 0);
    check("ar_stall", 32'(d2_stall), 0);
    tick();
    rst_n = 1'b1;
    #1 check("ar_release_stall", 32'(d2_stall), 0);
    tick();
    check("ar_next_valid", 32'(d2_valid), 1);

    // Reset mid-STALL resumes in RUN with no residual stall
    load_to_dest4();
    drive(1'b1, 4'd6, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    tick();
    check("rs_in_stall_l3", 32'(d3_stall), 1);
    rst_n = 1'b0;
    #1 check("rs_stall_l3", 32'(d3_stall), 0);
    tick();
    rst_n = 1'b1;
    #1 check("rs_release_stall_l3", 32'(d3_stall), 0);
    tick();
    check("rs_next_valid_l3", 32'(d3_valid), 1);
    check("rs_next_r3_val_l3", d3_r3_val, 32'h44);

`ifdef DECODE_EXEC_STALL_COUNT_EN
    rst_n = 1'b0;
    #1 check("sc_rst", d2_cnt, 0);
    tick();
    rst_n = 1'b1;
    load_to_dest4();
    drive(1'b1, 4'd6, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    tick();
    tick();
    tick();
    check("sc_two", d2_cnt, 2);
    load_to_dest4();
    force dut2.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut2.stall_cnt;
    drive(1'b1, 4'd6, 4'd4, 32'h66, 32'h44, 4'd7, 1'b1, 1'b0, 8'h22);
    tick();
    check("sc_wrap", d2_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
